// File: rtl/vx_smem_responder.sv
// Banked shared-memory responder for the core-side dcache request/response protocol.
// Optional bank-conflict counter perf_bank_stalls_o is built when SMEM_CONFLICT_CTR_EN is defined.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef SMEM_SIZE
`define SMEM_SIZE 1024
`endif
`ifndef DCACHE_CORE_TAG_WIDTH
`define DCACHE_CORE_TAG_WIDTH 8
`endif
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module vx_smem_responder #(
  parameter int CORE_ID   = 0,
  parameter int SIZE      = `SMEM_SIZE,
  parameter int NUM_BANKS = 4,
  parameter int TAG_WIDTH = `DCACHE_CORE_TAG_WIDTH
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [`NUM_THREADS-1:0]                     dcache_req_valid_i,
  input  logic [`NUM_THREADS-1:0]                     dcache_req_rw_i,
  input  logic [`NUM_THREADS-1:0][29:0]               dcache_req_addr_i,
  input  logic [`NUM_THREADS-1:0][3:0]                dcache_req_byteen_i,
  input  logic [`NUM_THREADS-1:0][31:0]               dcache_req_data_i,
  input  logic [`NUM_THREADS-1:0][TAG_WIDTH-1:0]      dcache_req_tag_i,
  output logic [`NUM_THREADS-1:0]                     dcache_req_ready_o,
  output logic                                        dcache_rsp_valid_o,
  output logic [`NUM_THREADS-1:0]                     dcache_rsp_tmask_o,
  output logic [`NUM_THREADS-1:0][31:0]               dcache_rsp_data_o,
  output logic [TAG_WIDTH-1:0]                        dcache_rsp_tag_o,
  input  logic                                        dcache_rsp_ready_i
`ifdef SMEM_CONFLICT_CTR_EN
  ,
  output logic [`PERF_CTR_BITS-1:0]                   perf_bank_stalls_o
`endif
);
  localparam int NT   = `NUM_THREADS;
  localparam int WA   = $clog2(SIZE / 4);
  localparam int BB   = $clog2(NUM_BANKS);
  localparam int RB   = WA - BB;
  localparam int ROWS = SIZE / (4 * NUM_BANKS);

  logic [31:0] mem_q [NUM_BANKS][ROWS];

  logic [NT-1:0][BB-1:0]        bank;
  logic [NT-1:0][RB-1:0]        row;
  logic                         lead_rw;
  logic [TAG_WIDTH-1:0]         lead_tag;
  logic [NT-1:0]                eligible, granted, fire;
  logic                         stall, rd_fire;
  logic                         win_found;
  logic [RB-1:0]                win_row;
  logic [NUM_BANKS-1:0]         wr_en;
  logic [NUM_BANKS-1:0][RB-1:0] wr_row;
  logic [NUM_BANKS-1:0][31:0]   wr_data;
  logic [NUM_BANKS-1:0][3:0]    wr_be;

  logic                         rsp_valid_q, rsp_valid_d;
  logic [NT-1:0]                rsp_tmask_q, rsp_tmask_d;
  logic [NT-1:0][31:0]          rsp_data_q, rsp_data_d;
  logic [TAG_WIDTH-1:0]         rsp_tag_q, rsp_tag_d;

  logic unused_bits;
  assign unused_bits = ^{dcache_req_addr_i, 32'(CORE_ID)};

  // Leader is the lowest valid lane; scan downward so the lowest index lands last.
  always_comb begin
    lead_rw  = 1'b0;
    lead_tag = '0;
    for (int i = NT - 1; i >= 0; i--) begin
      bank[i] = dcache_req_addr_i[i][BB-1:0];
      row[i]  = dcache_req_addr_i[i][WA-1:BB];
      if (dcache_req_valid_i[i]) begin
        lead_rw  = dcache_req_rw_i[i];
        lead_tag = dcache_req_tag_i[i];
      end
    end
    for (int i = 0; i < NT; i++) begin
      eligible[i] = dcache_req_valid_i[i] && (dcache_req_rw_i[i] == lead_rw)
                    && (dcache_req_tag_i[i] == lead_tag);
    end
  end

  // Per lane: find the lowest eligible lane on the same bank; reads sharing its row ride along.
  always_comb begin
    granted   = '0;
    win_found = 1'b0;
    win_row   = '0;
    for (int i = 0; i < NT; i++) begin
      win_found = 1'b0;
      win_row   = '0;
      for (int j = 0; j < i; j++) begin
        if (!win_found && eligible[j] && (bank[j] == bank[i])) begin
          win_found = 1'b1;
          win_row   = row[j];
        end
      end
      granted[i] = eligible[i] && (!win_found || (!lead_rw && (win_row == row[i])));
    end
  end

  assign stall              = rsp_valid_q && !dcache_rsp_ready_i;
  assign fire               = (reset || stall) ? '0 : granted;
  assign rd_fire            = (|fire) && !lead_rw;
  assign dcache_req_ready_o = fire;

  always_comb begin
    wr_en   = '0;
    wr_row  = '0;
    wr_data = '0;
    wr_be   = '0;
    for (int i = 0; i < NT; i++) begin
      if (fire[i] && lead_rw) begin
        wr_en[bank[i]]   = 1'b1;
        wr_row[bank[i]]  = row[i];
        wr_data[bank[i]] = dcache_req_data_i[i];
        wr_be[bank[i]]   = dcache_req_byteen_i[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wr_en[b]) begin
        for (int k = 0; k < 4; k++) begin
          if (wr_be[b][k]) mem_q[b][wr_row[b]][8*k +: 8] <= wr_data[b][8*k +: 8];
        end
      end
    end
  end

  // Response register: loaded on a read fire, held while stalled, cleared once consumed.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_tmask_d = rsp_tmask_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    if (rd_fire) begin
      rsp_valid_d = 1'b1;
      rsp_tmask_d = fire;
      rsp_tag_d   = lead_tag;
      for (int i = 0; i < NT; i++) rsp_data_d[i] = mem_q[bank[i]][row[i]];
    end else if (dcache_rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_tmask_q <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_tmask_q <= rsp_tmask_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  assign dcache_rsp_valid_o = rsp_valid_q;
  assign dcache_rsp_tmask_o = rsp_tmask_q;
  assign dcache_rsp_data_o  = rsp_data_q;
  assign dcache_rsp_tag_o   = rsp_tag_q;

`ifdef SMEM_CONFLICT_CTR_EN
  logic [`PERF_CTR_BITS-1:0] ctr_q, ctr_d;
  assign ctr_d = (!stall && |(eligible & ~granted) && !(&ctr_q)) ? ctr_q + 1'b1 : ctr_q;
  always_ff @(posedge clk) begin
    if (reset) ctr_q <= '0;
    else       ctr_q <= ctr_d;
  end
  assign perf_bank_stalls_o = ctr_q;
`endif

endmodule

// File: tb/tb_vx_smem_responder.sv
// Directed + randomized bench for vx_smem_responder against a flat word-array reference model.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module tb_vx_smem_responder;
  localparam int NT = 4, NB = 4, TW = 8, SZ = 256, WORDS = SZ / 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NT-1:0]          req_valid, req_rw, req_ready;
  logic [NT-1:0][29:0]    req_addr;
  logic [NT-1:0][3:0]     req_byteen;
  logic [NT-1:0][31:0]    req_data;
  logic [NT-1:0][TW-1:0]  req_tag;
  logic                   rsp_valid, rsp_ready;
  logic [NT-1:0]          rsp_tmask;
  logic [NT-1:0][31:0]    rsp_data;
  logic [TW-1:0]          rsp_tag;
`ifdef SMEM_CONFLICT_CTR_EN
  logic [`PERF_CTR_BITS-1:0] perf;
`endif

  vx_smem_responder #(.CORE_ID(0), .SIZE(SZ), .NUM_BANKS(NB), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .dcache_req_valid_i(req_valid), .dcache_req_rw_i(req_rw), .dcache_req_addr_i(req_addr),
    .dcache_req_byteen_i(req_byteen), .dcache_req_data_i(req_data), .dcache_req_tag_i(req_tag),
    .dcache_req_ready_o(req_ready),
    .dcache_rsp_valid_o(rsp_valid), .dcache_rsp_tmask_o(rsp_tmask), .dcache_rsp_data_o(rsp_data),
    .dcache_rsp_tag_o(rsp_tag), .dcache_rsp_ready_i(rsp_ready)
`ifdef SMEM_CONFLICT_CTR_EN
    , .perf_bank_stalls_o(perf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Reference model state
  logic [31:0]   ref_mem [WORDS];
  bit            m_pend;
  logic [NT-1:0] m_tmask;
  logic [TW-1:0] m_tag;
  logic [31:0]   m_data [NT];
  logic [NT-1:0] exp_grant, last_ready;
  bit            exp_conflict, m_stall, m_lead_rw;
  logic [TW-1:0] m_lead_tag;
  longint        exp_ctr;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic int word_of(input int i);
    return int'(req_addr[i] % WORDS);
  endfunction

  // Which lanes the memory should accept this cycle, from the protocol rules.
  function automatic void model_comb();
    bit claimed [NB];
    int cw [NB];
    int lead = -1;
    for (int b = 0; b < NB; b++) begin claimed[b] = 0; cw[b] = 0; end
    exp_grant = '0;
    exp_conflict = 0;
    m_stall = m_pend && !rsp_ready;
    for (int i = NT - 1; i >= 0; i--) if (req_valid[i]) lead = i;
    if (lead < 0) return;
    m_lead_rw  = req_rw[lead];
    m_lead_tag = req_tag[lead];
    for (int i = 0; i < NT; i++) begin
      if (req_valid[i] && req_rw[i] == m_lead_rw && req_tag[i] == m_lead_tag) begin
        int w = word_of(i);
        int b = w % NB;
        if (!claimed[b]) begin
          claimed[b] = 1; cw[b] = w; exp_grant[i] = 1'b1;
        end else if (!m_lead_rw && cw[b] == w) exp_grant[i] = 1'b1;
        else exp_conflict = 1;
      end
    end
    if (m_stall || reset) exp_grant = '0;
  endfunction

  function automatic void model_commit();
    if (reset) begin
      m_pend = 0; m_tmask = '0; m_tag = '0; exp_ctr = 0;
      for (int i = 0; i < NT; i++) m_data[i] = '0;
      return;
    end
    if (!m_stall && exp_conflict && exp_ctr != (64'd1 << `PERF_CTR_BITS) - 1) exp_ctr++;
    if (exp_grant != 0 && !m_lead_rw) begin
      m_pend = 1; m_tmask = exp_grant; m_tag = m_lead_tag;
      for (int i = 0; i < NT; i++) if (exp_grant[i]) m_data[i] = ref_mem[word_of(i)];
    end else begin
      for (int i = 0; i < NT; i++)
        if (exp_grant[i])
          for (int k = 0; k < 4; k++)
            if (req_byteen[i][k]) ref_mem[word_of(i)][8*k +: 8] = req_data[i][8*k +: 8];
      if (rsp_ready) m_pend = 0;
    end
  endfunction

  task automatic check_outputs();
    logic [NT*32-1:0] obs, exp;
    chk("rsp_valid", rsp_valid, m_pend);
    if (reset) begin
      chk("rst_tmask", rsp_tmask, '0);
      chk("rst_tag", rsp_tag, '0);
      chk("rst_data", rsp_data, '0);
    end
    if (m_pend) begin
      chk("rsp_tmask", rsp_tmask, m_tmask);
      chk("rsp_tag", rsp_tag, m_tag);
      obs = '0; exp = '0;
      for (int i = 0; i < NT; i++) if (m_tmask[i]) begin
        obs[32*i +: 32] = rsp_data[i];
        exp[32*i +: 32] = m_data[i];
      end
      chk("rsp_data", obs, exp);
    end
`ifdef SMEM_CONFLICT_CTR_EN
    chk("perf_bank_stalls", perf, exp_ctr);
`endif
  endtask

  task automatic cycle();
    #3;
    model_comb();
    last_ready = req_ready;
    chk("ready", req_ready, exp_grant);
    @(posedge clk); #1;
    model_commit();
    check_outputs();
  endtask

  task automatic set_lane(input int i, input bit rw, input int word, input logic [3:0] be,
                          input logic [31:0] d, input logic [TW-1:0] t);
    req_valid[i]  = 1'b1;
    req_rw[i]     = rw;
    req_addr[i]   = {24'($urandom), 6'(word)};
    req_byteen[i] = be;
    req_data[i]   = d;
    req_tag[i]    = t;
  endtask

  task automatic clear_lanes();
    req_valid = '0; req_rw = '0; req_addr = '0; req_byteen = '0; req_data = '0; req_tag = '0;
  endtask

  logic [TW-1:0]       saved_tag;
  logic [NT-1:0][31:0] saved_data;
`ifdef SMEM_CONFLICT_CTR_EN
  longint ctr_before;
`endif

  initial begin
    for (int w = 0; w < WORDS; w++) ref_mem[w] = 'x;
    m_pend = 0; exp_ctr = 0; m_lead_rw = 0; m_lead_tag = '0;
    reset = 1'b1; rsp_ready = 1'b1;
    clear_lanes();
    @(posedge clk); #1;

    // Reset with all lanes requesting writes of words 0..3
    for (int i = 0; i < NT; i++) set_lane(i, 1'b1, i, 4'hF, 32'hA0 + i, 8'h00);
    repeat (3) begin
      cycle();
      chk("reset_ready", last_ready, 4'b0000);
    end
    reset = 1'b0;
    cycle();
    chk("ready_after_reset", |last_ready, 1'b1);

    // Read back words 0..3 in one shot
    for (int i = 0; i < NT; i++) set_lane(i, 1'b0, i, 4'h0, 32'h0, 8'h15);
    cycle();
    clear_lanes();
    chk("rd4_tmask", rsp_tmask, 4'hF);
    chk("rd4_data", rsp_data, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    chk("rd4_tag", rsp_tag, 8'h15);

    // Fill the rest of memory so every word is known
    for (int r = 1; r < WORDS / NB; r++) begin
      for (int i = 0; i < NT; i++) set_lane(i, 1'b1, r * NB + i, 4'hF, $urandom, 8'h01);
      cycle();
      clear_lanes();
    end

    // Bank conflict: words 0 and 4 on bank 0
`ifdef SMEM_CONFLICT_CTR_EN
    ctr_before = exp_ctr;
`endif
    set_lane(0, 1'b0, 0, 4'h0, 0, 8'h03);
    set_lane(1, 1'b0, 4, 4'h0, 0, 8'h03);
    cycle();
    chk("conf_ready_T", last_ready, 4'b0001);
    chk("conf_tmask_T1", rsp_tmask, 4'b0001);
    req_valid[0] = 1'b0;
    cycle();
    chk("conf_ready_T1", last_ready, 4'b0010);
    chk("conf_tmask_T2", rsp_tmask, 4'b0010);
    chk("conf_tag_T2", rsp_tag, 8'h03);
`ifdef SMEM_CONFLICT_CTR_EN
    chk("conf_ctr_inc", perf, ctr_before + 1);
`endif
    clear_lanes();

    // Broadcast
    set_lane(0, 1'b1, 5, 4'hF, 32'hDEADBEEF, 8'h00);
    cycle();
    clear_lanes();
    for (int i = 0; i < NT; i++) set_lane(i, 1'b0, 5, 4'h0, 0, 8'h22);
    cycle();
    clear_lanes();
    chk("bcast_ready", last_ready, 4'hF);
    chk("bcast_tmask", rsp_tmask, 4'hF);
    chk("bcast_data", rsp_data, {4{32'hDEADBEEF}});

    // Byte-masked write
    set_lane(2, 1'b1, 8, 4'hF, 32'h11223344, 8'h00);
    cycle();
    set_lane(2, 1'b1, 8, 4'b0010, 32'h0000BB00, 8'h00);
    cycle();
    clear_lanes();
    set_lane(0, 1'b0, 8, 4'h0, 0, 8'h05);
    cycle();
    clear_lanes();
    chk("bytewr_data", rsp_data[0], 32'h1122BB44);

    // Backpressure
    set_lane(0, 1'b0, 1, 4'h0, 0, 8'h07);
    cycle();
    clear_lanes();
    saved_tag = rsp_tag; saved_data = rsp_data;
    rsp_ready = 1'b0;
    set_lane(1, 1'b0, 2, 4'h0, 0, 8'h09);
    repeat (3) begin
      cycle();
      chk("bp_ready", last_ready, 4'b0000);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_tag", rsp_tag, saved_tag);
      chk("bp_data", rsp_data, saved_data);
    end
    rsp_ready = 1'b1;
    cycle();
    clear_lanes();
    chk("bp_release_ready", last_ready, 4'b0010);
    chk("bp_release_tmask", rsp_tmask, 4'b0010);
    chk("bp_release_tag", rsp_tag, 8'h09);

    // Randomized traffic: lanes hold their request until accepted
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NT; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_lane(i, $urandom_range(0, 9) < 3, $urandom_range(0, 15), 4'($urandom),
                   $urandom, 8'($urandom_range(0, 1)));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
      for (int i = 0; i < NT; i++) if (exp_grant[i]) req_valid[i] = 1'b0;
    end

    // Mid-traffic reset drops any pending response
    reset = 1'b1;
    rsp_ready = 1'b0;
    cycle();
    chk("rst_drop_valid", rsp_valid, 1'b0);
    reset = 1'b0;
    clear_lanes();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
